// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter slice.
// State encodings and elaboration-time helpers.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_START = 2'b01,
    ARB_WAIT  = 2'b10
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request
// scanning upward from last+1 with wrap-around.
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int k;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (int'(last) + i) % N_REQ;
      if (!valid && req[k]) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX serializer, one byte
// per grant, with a done-tick watchdog.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int NB_DATA        = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int IDX_W = clog2(N_REQ),
  localparam int CNT_R = clog2(TIMEOUT_CYCLES + 1),
  localparam int CNT_W = (CNT_R < 1) ? 1 : CNT_R
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done_tick,
  output logic                     o_busy,
  output logic [IDX_W-1:0]         o_grant_idx,
  output logic                     o_timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [N_REQ-1:0]   ack_nxt;
  logic               start_nxt;
  logic [NB_DATA-1:0] data_nxt;
  logic               busy_nxt;
  logic [IDX_W-1:0]   grant_nxt;
  logic               timeout_nxt;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NB_DATA-1:0] pick_byte;

  rr_priority_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req  (i_req),
    .last (o_grant_idx),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_comb begin
    pick_byte = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_idx == IDX_W'(j))
        pick_byte = i_data[j*NB_DATA +: NB_DATA];
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ack_nxt     = '0;
    start_nxt   = 1'b0;
    data_nxt    = o_tx_data;
    busy_nxt    = o_busy;
    grant_nxt   = o_grant_idx;
    timeout_nxt = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_nxt         = pick_idx;
          data_nxt          = pick_byte;
          ack_nxt[pick_idx] = 1'b1;
          start_nxt         = 1'b1;
          busy_nxt          = 1'b1;
          state_nxt         = ARB_START;
        end
      end
      ARB_START: begin
        cnt_nxt   = '0;
        state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (WDOG_EN && cnt != CNT_MAX)
          cnt_nxt = cnt + 1'b1;
        // done beats a simultaneous watchdog expiry
        if (i_tx_done_tick) begin
          busy_nxt  = 1'b0;
          state_nxt = ARB_IDLE;
        end else if (WDOG_EN && cnt == CNT_LAST) begin
          timeout_nxt = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ARB_IDLE;
      cnt         <= '0;
      o_ack       <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_busy      <= 1'b0;
      o_grant_idx <= IDX_W'(N_REQ - 1);
      o_timeout   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_ack       <= ack_nxt;
      o_tx_start  <= start_nxt;
      o_tx_data   <= data_nxt;
      o_busy      <= busy_nxt;
      o_grant_idx <= grant_nxt;
      o_timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are
// queued when requests are driven and popped on each start.
module tb_uart_tx_arbiter;

  localparam int N_REQ          = 2;
  localparam int NB_DATA        = 8;
  localparam int TIMEOUT_CYCLES = 50;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [N_REQ-1:0]         req = '0;
  logic [N_REQ*NB_DATA-1:0] data = '0;
  logic                     done = 1'b0;
  logic [N_REQ-1:0]         o_ack;
  logic                     o_tx_start;
  logic [NB_DATA-1:0]       o_tx_data;
  logic                     o_busy;
  logic                     o_grant_idx;
  logic                     o_timeout;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  int         n_start = 0;
  int         n_timeout = 0;
  logic [7:0] cur = '0;

  uart_tx_arbiter #(
    .N_REQ         (N_REQ),
    .NB_DATA       (NB_DATA),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_req         (req),
    .i_data        (data),
    .o_ack         (o_ack),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .i_tx_done_tick(done),
    .o_busy        (o_busy),
    .o_grant_idx   (o_grant_idx),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (o_tx_start) begin
        n_start++;
        cur = o_tx_data;
        if (q.size() == 0) begin
          check("extra_start", 1, 0);
        end else begin
          e = q.pop_front();
          check("tx_data", o_tx_data, e.data);
          check("ack", o_ack, 32'(1 << e.idx));
          check("grant", o_grant_idx, e.idx);
          check("busy_at_start", o_busy, 1);
        end
      end else begin
        if (o_ack != '0) check("stray_ack", o_ack, 0);
        if (o_busy) check("data_stable", o_tx_data, cur);
      end
      if (o_timeout) n_timeout++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    cyc(2);
    rst  = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!o_tx_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_tx_start) check("start_wait_expired", 0, 1);
  endtask

  initial begin
    int n;
    int k;
    do_reset();
    check("rst_busy", o_busy, 0);
    check("rst_grant", o_grant_idx, 1);
    check("rst_ack", o_ack, 0);
    check("rst_start", o_tx_start, 0);
    check("rst_data", o_tx_data, 0);
    check("rst_timeout", o_timeout, 0);

    // single requester
    data[7:0] = 8'h55;
    req = 2'b01;
    q.push_back('{8'h55, 0});
    wait_start(n);
    check("t1_latency", n, 1);
    req = '0;
    cyc(19);
    pulse_done();
    check("t1_busy_after_done", o_busy, 0);

    // fairness and back-to-back
    do_reset();
    data = {8'hB2, 8'hA1};
    req = 2'b11;
    q.push_back('{8'hA1, 0});
    q.push_back('{8'hB2, 1});
    q.push_back('{8'hA1, 0});
    wait_start(n);
    check("t2_latency", n, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(19);
      pulse_done();
      check("b2b_gap_start", o_tx_start, 0);
      check("b2b_gap_busy", o_busy, 0);
      @(negedge clk);
      check("b2b_next_start", o_tx_start, 1);
    end
    req = '0;
    cyc(19);
    pulse_done();
    check("t2_busy_end", o_busy, 0);
    cyc(3);
    check("t2_queue_drained", q.size(), 0);

    // watchdog
    do_reset();
    data = {8'hD4, 8'hC3};
    req = 2'b11;
    q.push_back('{8'hC3, 0});
    q.push_back('{8'hD4, 1});
    wait_start(n);
    k = 0;
    while (!o_timeout && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, 51);
    check("timeout_busy", o_busy, 0);
    @(negedge clk);
    check("timeout_one_cycle", o_timeout, 0);
    check("timeout_next_start", o_tx_start, 1);
    req = '0;
    cyc(5);
    pulse_done();
    check("timeout_count", n_timeout, 1);

    // reset while waiting for done
    data[7:0] = 8'h11;
    req = 2'b01;
    q.push_back('{8'h11, 0});
    wait_start(n);
    req = '0;
    cyc(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_grant", o_grant_idx, 1);
    check("mid_rst_ack", o_ack, 0);
    check("mid_rst_timeout", o_timeout, 0);
    cyc(3);
    check("mid_rst_no_timeout", n_timeout, 1);
    data[15:8] = 8'h22;
    req = 2'b10;
    q.push_back('{8'h22, 1});
    wait_start(n);
    check("t5_latency", n, 1);
    req = '0;
    cyc(10);
    pulse_done();
    check("t5_busy_end", o_busy, 0);

    // spurious done ticks in IDLE and START
    pulse_done();
    check("sp_idle_busy", o_busy, 0);
    check("sp_idle_start", o_tx_start, 0);
    check("sp_idle_grant", o_grant_idx, 1);
    data[7:0] = 8'h5A;
    req = 2'b01;
    q.push_back('{8'h5A, 0});
    wait_start(n);
    done = 1'b1;
    req = '0;
    @(negedge clk);
    done = 1'b0;
    check("sp_start_busy", o_busy, 1);
    cyc(10);
    check("sp_wait_busy", o_busy, 1);
    pulse_done();
    check("sp_done_busy", o_busy, 0);
    cyc(3);

    check("final_queue", q.size(), 0);
    check("final_starts", n_start, 9);
    check("final_timeouts", n_timeout, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1 TX serializer with start/data/done-tick handshake) between N_REQ byte requesters, e.g. the ALU result path and a status/echo path.
- Arbitration is round-robin. The block sequences exactly one byte per grant: it issues a one-cycle start pulse, then waits for the transmitter's done tick.
- A watchdog timeout recovers the block if the done tick never arrives.
- Sits between the requesters and the TX serializer, in the same clock domain as the baud-tick generator.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- NB_DATA, 8, byte width; must match the transmitter's data width.
- TIMEOUT_CYCLES, 1_000_000, maximum i_clk cycles to wait for the done tick; 0 disables the watchdog.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level; held until the matching o_ack.
- i_data  in  N_REQ*NB_DATA  flattened bytes; requester k occupies bits [k*NB_DATA +: NB_DATA].
- o_ack  out  N_REQ  one-hot, one-cycle pulse; the byte of that requester has been accepted.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- o_tx_data  out  NB_DATA  registered byte to the transmitter; stable from o_tx_start until done.
- i_tx_done_tick  in  1  one-cycle completion tick from the transmitter.
- o_busy  out  1  high while a byte is owned by the transmitter.
- o_grant_idx  out  clog2(N_REQ)  index of the current or most recent winner.
- o_timeout  out  1  one-cycle pulse when the watchdog expires.

Behaviour:
- Reset (synchronous, on i_clk edge with i_reset=1) values:
  - state=IDLE.
  - o_ack=0, o_tx_start=0, o_tx_data=0, o_busy=0, o_timeout=0.
  - o_grant_idx=N_REQ-1, so requester 0 wins first.
  - watchdog counter=0.
- Reset mid-transfer: the block abandons the byte and issues no ack or timeout. The transmitter shares the same reset.
- States: IDLE, START, WAIT_DONE. All outputs are registered.
- IDLE:
  - If any i_req bit is set, the winner is the first set bit scanning upward from (o_grant_idx+1) mod N_REQ, with wrap-around.
  - Registered on the next edge: o_grant_idx=winner, o_tx_data=winner's byte, o_ack[winner]=1, o_tx_start=1, o_busy=1, state->START.
- START (exactly 1 cycle):
  - o_tx_start and o_ack are high in this cycle only.
  - Next state is WAIT_DONE; watchdog counter is cleared.
  - An i_tx_done_tick seen in START is ignored.
- WAIT_DONE:
  - o_busy=1. The counter increments every cycle.
  - On i_tx_done_tick: o_busy->0, state->IDLE. A new grant can start on the following cycle (back-to-back bytes, one idle cycle between done and start).
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without a done tick: o_timeout pulses 1 cycle, o_busy->0, state->IDLE.
  - If done and timeout happen in the same cycle, done wins and there is no timeout pulse.
- i_tx_done_tick in IDLE is ignored.
- Requests change only in IDLE evaluation; bits raised in START or WAIT_DONE wait for the next arbitration.
- A requester dropping i_req before its ack is legal; it is simply not considered.
- Fairness: with all requesters active, grants rotate 0,1,...,N_REQ-1,0,...
- Watchdog counter width is clog2(TIMEOUT_CYCLES+1), saturating. The counter is held at 0 when the watchdog is disabled.
- Latency: request seen in IDLE at edge t -> o_tx_start high in cycle t+1.

Decomposition:
- Shared package/header holds:
  - ARB_IDLE=2'b00, ARB_START=2'b01, ARB_WAIT=2'b10 state encodings.
  - The clog2 function.
- Natural sub-module: rr_priority_picker. Purely combinational; inputs are the req vector and last index; outputs are valid plus the winner index. It is reused by future arbiters and is testable standalone.

Test Plan:
1. Reset then i_req=01, data0=0x55 -> 1 cycle later o_tx_start=1, o_tx_data=0x55, o_ack=01, o_grant_idx=0, o_busy=1; after done tick o_busy=0.
2. i_req=11 held, data0=0xA1, data1=0xB2, done tick 20 cycles after each start -> bytes sent in order 0xA1, 0xB2, 0xA1; acks alternate 01,10,01.
3. Back-to-back: done tick then i_req still active -> next o_tx_start exactly 2 cycles after the done tick; o_tx_data is stable throughout WAIT_DONE.
4. TIMEOUT_CYCLES=50, no done tick -> o_timeout pulses once 51 cycles after o_tx_start; block returns to IDLE and grants the next requester.
5. Assert i_reset in WAIT_DONE -> next cycle o_busy=0, o_grant_idx=N_REQ-1, no o_ack and no o_timeout; the subsequent request from requester 1 alone is granted normally.
6. Spurious i_tx_done_tick in IDLE and in START -> no state change, no extra o_ack, and the transfer completes only on the real done tick.
